access_control_n: RTL and testbench
===================================

# access_control_n

Parametrised successor to the two-channel access-control block in the Scrambled-Number SUM Game. A serial code is entered one bit per cycle from `swtch` while `psh` is high. A correct code opens N_CH load channels, which pass `ldIn` to `ld_out`. Wrong codes consume tries, and exhausting the tries forces a timed lockout. The block sits between the board switches/pushbuttons and the game's load-enable logic.

## Interface
Parameters:
- CODE_LEN, 4: number of code bits per attempt; must be at least 2.
- CODE, 4'b1101: expected code, CODE_LEN bits wide; the first bit entered is compared against the MSB.
- N_CH, 2: number of gated load channels; must be at least 1.
- MAX_TRIES, 3: wrong attempts allowed before lockout; must be at least 1.
- LOCK_CYCLES, 8: lockout duration in clocks; must be at least 1.

Ports:
- Clk  in  1  system clock; rising edge active.
- Rst  in  1  reset, asynchronous, active-high.
- psh  in  1  entry enable; when high in a cycle, `swtch` is sampled at that edge.
- swtch  in  1  code bit.
- lock  in  1  relock request, level-sampled.
- ldIn  in  N_CH  load requests.
- ld_out  out  N_CH  gated loads, registered.
- led_grant  out  1  high while in GRANT.
- led_deny  out  1  high while in DENY.
- locked  out  1  high while in LOCKOUT.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.

## Operation
- States: ENTER, GRANT, DENY, LOCKOUT. All outputs are Moore-decoded from registered state.
- Reset values: state ENTER, shift register 0, bit count 0, tries_left = MAX_TRIES, lockout counter 0, ld_out = 0, led_grant = led_deny = locked = 0.

ENTER:
- While psh = 1, shift `swtch` into the LSB of the shift register and increment the bit count.
- When psh = 0, hold the shift register and bit count.
- On the edge that samples bit number CODE_LEN, compare the CODE_LEN-bit value including that bit against CODE, then clear the bit count.
- Match: go to GRANT and reload tries_left = MAX_TRIES.
- Mismatch: go to DENY and decrement tries_left.

GRANT:
- Each edge, ld_out <= ldIn.
- When lock = 1: go to ENTER, clear ld_out, clear the shift register.

DENY:
- Lasts exactly 1 cycle.
- Next state is ENTER if tries_left ≠ 0, otherwise LOCKOUT with the lockout counter loaded to LOCK_CYCLES.

LOCKOUT:
- Decrement the lockout counter each edge.
- On the edge where the counter reads 1: go to ENTER and reload tries_left = MAX_TRIES.

Behaviour outside the normal flow:
- psh is ignored in GRANT, DENY and LOCKOUT; bits seen there are never counted.
- lock in ENTER clears the partial entry (bit count and shift register to 0). lock takes priority over psh in the same cycle.
- lock has no effect in DENY or LOCKOUT.
- ld_out is 0 in every state except GRANT.
- Partial entries persist indefinitely in ENTER; there is no entry timeout.
- Asserting Rst at any time, including mid-entry or mid-lockout, forces the reset values immediately, without waiting for a clock edge.

## Timing
- Code-bit to decision: led_grant or led_deny rises 1 cycle after the edge sampling the last bit.
- Load latency: in GRANT, ld_out follows ldIn with 1 cycle of latency. The first valid ld_out is the cycle after led_grant rises.
- Relock: lock sampled high at edge k gives ld_out = 0 and led_grant = 0 after edge k.
- led_deny pulse width is exactly 1 cycle.
- locked stays high for exactly LOCK_CYCLES cycles.
- tries_left updates on the same edge as the state change into DENY or GRANT.
- Back-to-back entry: psh may stay high continuously. The attempt completes at the CODE_LEN-th bit, and any psh during DENY is dropped. A new attempt starts at the first ENTER cycle.

## Test plan
All scenarios use default parameters.
1. Correct code: reset, then psh = 1 with swtch 1,1,0,1 on consecutive edges. Required: led_grant = 1 one cycle after the 4th bit, tries_left = 3. Then ldIn = 2'b01 gives ld_out = 2'b01 the next cycle, and ldIn = 2'b11 gives ld_out = 2'b11.
2. Wrong code then correct: enter 1,0,1,0. Required: a one-cycle led_deny pulse, tries_left = 2, ld_out stays 0. Then enter 1,1,0,1: led_grant = 1 and tries_left = 3.
3. Lockout: three wrong codes (0,0,0,0 each). Required: tries_left goes 2, 1, 0, then locked = 1 for exactly 8 cycles. psh activity during the lockout is ignored. Afterwards state is ENTER with tries_left = 3, and 1,1,0,1 grants.
4. psh gaps and lock abort: enter 1,1 with psh, drop psh for 5 cycles, then enter 0,1. Required: grant. In a separate attempt, enter 1,1, pulse lock, then enter 0,1. Required: no decision yet (bit count = 2), and completing with 1,1,0,1 grants.
5. Relock and async reset: in GRANT with ldIn = 2'b11, assert lock. Required: ld_out = 0 and led_grant = 0 next cycle. In a separate run, assert Rst between clock edges mid-lockout. Required: locked = 0 and tries_left = 3 immediately, without waiting for an edge.
6. Generalisation: rerun scenarios 1 and 3 with CODE_LEN = 6, CODE = 6'b101100, N_CH = 4, MAX_TRIES = 1, LOCK_CYCLES = 3. Required: one wrong attempt leads directly to a 3-cycle lockout, and a correct code passes all 4 channels.

Source files
------------

// File: rtl/access_control_n_if.sv
// access_control_n_if: board-side signal bundle for access_control_n.
//   master : the switch/pushbutton side (drives psh, swtch, lock, ldIn)
//   slave  : the access-control block (drives ld_out, LEDs, tries_left)
//   psh        entry enable; swtch is sampled on edges where psh is high
//   swtch      serial code bit, MSB of the code entered first
//   lock       relock / abort-entry request, level-sampled
//   ldIn       N_CH raw load requests
//   ld_out     N_CH gated loads, registered
//   led_grant  high while access is granted
//   led_deny   one-cycle pulse after a wrong code
//   locked     high during the timed lockout
//   tries_left remaining wrong attempts before lockout
interface access_control_n_if #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

    logic              psh;
    logic              swtch;
    logic              lock;
    logic [N_CH-1:0]   ldIn;
    logic [N_CH-1:0]   ld_out;
    logic              led_grant;
    logic              led_deny;
    logic              locked;
    logic [TriesW-1:0] tries_left;

    modport master (
        output psh, swtch, lock, ldIn,
        input  ld_out, led_grant, led_deny, locked, tries_left
    );

    modport slave (
        input  psh, swtch, lock, ldIn,
        output ld_out, led_grant, led_deny, locked, tries_left
    );
endinterface

// File: rtl/access_control_n.sv
// access_control_n: serial-code access control gating N_CH load channels.
// A CODE_LEN-bit code is shifted in MSB-first from swtch on edges where psh
// is high. A match opens the load channels (ld_out follows ldIn one cycle
// late) until lock is raised. A mismatch costs one try; running out of tries
// forces a LOCK_CYCLES-clock lockout, after which the tries are restored.
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-high reset
//   bus  access_control_n_if.slave (psh, swtch, lock, ldIn in;
//        ld_out, led_grant, led_deny, locked, tries_left out)
module access_control_n #(
    parameter int unsigned         CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b1101,
    parameter int unsigned         N_CH        = 2,
    parameter int unsigned         MAX_TRIES   = 3,
    parameter int unsigned         LOCK_CYCLES = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    access_control_n_if.slave   bus
);
    // Bit count only needs to reach CODE_LEN-1: it clears on the deciding bit.
    localparam int unsigned CntW   = $clog2(CODE_LEN);
    localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
    localparam int unsigned LockW  = $clog2(LOCK_CYCLES + 1);

    localparam logic [CntW-1:0]   CntLast  = CntW'(CODE_LEN - 1);
    localparam logic [TriesW-1:0] TriesMax = TriesW'(MAX_TRIES);
    localparam logic [LockW-1:0]  LockInit = LockW'(LOCK_CYCLES);

    if (CODE_LEN < 2) begin : g_bad_code_len
        $error("access_control_n: CODE_LEN must be at least 2");
    end
    if (N_CH < 1) begin : g_bad_n_ch
        $error("access_control_n: N_CH must be at least 1");
    end
    if (MAX_TRIES < 1) begin : g_bad_max_tries
        $error("access_control_n: MAX_TRIES must be at least 1");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("access_control_n: LOCK_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StEnter, StGrant, StDeny, StLockout} state_e;

    state_e              state_q;
    logic [CODE_LEN-1:0] sr_q;
    logic [CntW-1:0]     cnt_q;
    logic [TriesW-1:0]   tries_q;
    logic [LockW-1:0]    lock_cnt_q;
    logic [N_CH-1:0]     ld_q;
    logic                grant_q;
    logic                deny_q;
    logic                locked_q;

    // Shift-register value including the bit sampled at this edge, so the
    // deciding bit takes part in the comparison.
    logic [CODE_LEN-1:0] sr_shift;
    assign sr_shift = {sr_q[CODE_LEN-2:0], bus.swtch};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StEnter;
            sr_q       <= '0;
            cnt_q      <= '0;
            tries_q    <= TriesMax;
            lock_cnt_q <= '0;
            ld_q       <= '0;
            grant_q    <= 1'b0;
            deny_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StEnter: begin
                    if (bus.lock) begin
                        // Abort the partial entry; wins over a bit in the same cycle.
                        sr_q  <= '0;
                        cnt_q <= '0;
                    end else if (bus.psh) begin
                        sr_q <= sr_shift;
                        if (cnt_q == CntLast) begin
                            cnt_q <= '0;
                            if (sr_shift == CODE) begin
                                state_q <= StGrant;
                                grant_q <= 1'b1;
                                tries_q <= TriesMax;
                            end else begin
                                state_q <= StDeny;
                                deny_q  <= 1'b1;
                                tries_q <= tries_q - TriesW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StGrant: begin
                    if (bus.lock) begin
                        state_q <= StEnter;
                        grant_q <= 1'b0;
                        ld_q    <= '0;
                        sr_q    <= '0;
                    end else begin
                        ld_q <= bus.ldIn;
                    end
                end
                StDeny: begin
                    deny_q <= 1'b0;
                    if (tries_q != '0) begin
                        state_q <= StEnter;
                    end else begin
                        state_q    <= StLockout;
                        locked_q   <= 1'b1;
                        lock_cnt_q <= LockInit;
                    end
                end
                StLockout: begin
                    lock_cnt_q <= lock_cnt_q - LockW'(1);
                    if (lock_cnt_q == LockW'(1)) begin
                        state_q  <= StEnter;
                        locked_q <= 1'b0;
                        tries_q  <= TriesMax;
                    end
                end
                default: begin
                    state_q <= StEnter;
                end
            endcase
        end
    end

    assign bus.ld_out     = ld_q;
    assign bus.led_grant  = grant_q;
    assign bus.led_deny   = deny_q;
    assign bus.locked     = locked_q;
    assign bus.tries_left = tries_q;
endmodule

// File: tb/tb_access_control_n.sv
// Bench for access_control_n: directed vectors, expected outputs queued by the
// stimulus and checked by an independent monitor after each clock edge (or on
// demand for asynchronous-reset checks). dut_a uses the default parameters,
// dut_b the 6-bit / 4-channel / single-try variant.
module tb_access_control_n;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    access_control_n_if #(.N_CH(2), .MAX_TRIES(3)) ifa ();
    access_control_n_if #(.N_CH(4), .MAX_TRIES(1)) ifb ();

    access_control_n #(
        .CODE_LEN(4), .CODE(4'b1101), .N_CH(2), .MAX_TRIES(3), .LOCK_CYCLES(8)
    ) dut_a (
        .Clk(Clk),
        .Rst(Rst),
        .bus(ifa.slave)
    );

    access_control_n #(
        .CODE_LEN(6), .CODE(6'b101100), .N_CH(4), .MAX_TRIES(1), .LOCK_CYCLES(3)
    ) dut_b (
        .Clk(Clk),
        .Rst(Rst),
        .bus(ifb.slave)
    );

    typedef struct {
        bit         sel;   // 0: dut_a, 1: dut_b
        bit         g;
        bit         d;
        bit         lk;
        int         t;
        logic [3:0] ld;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    event chk_ev;

    // Drive one cycle of inputs to both DUTs at the falling edge.
    task automatic cyc(input bit p, input bit s, input bit l, input logic [3:0] ld);
        @(negedge Clk);
        ifa.psh   = p;
        ifa.swtch = s;
        ifa.lock  = l;
        ifa.ldIn  = ld[1:0];
        ifb.psh   = p;
        ifb.swtch = s;
        ifb.lock  = l;
        ifb.ldIn  = ld;
    endtask

    // Expected outputs after the next rising edge (or the next chk_ev).
    task automatic exp_out(input bit sel, input bit g, input bit d, input bit lk,
                           input int t, input logic [3:0] ld, input string nm);
        exp_t e;
        e.sel = sel;
        e.g   = g;
        e.d   = d;
        e.lk  = lk;
        e.t   = t;
        e.ld  = ld;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    // Shift in the low n bits of 'bits', MSB first, with psh held high.
    task automatic code(input logic [5:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, 4'b0000);
        end
    endtask

    // Monitor: compare every queued expectation after the edge it refers to.
    initial begin : monitor
        exp_t       e;
        logic       ag, ad, alk;
        int         at;
        logic [3:0] ald;
        forever begin
            @(posedge Clk or chk_ev);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel == 1'b0) begin
                    ag  = ifa.led_grant;
                    ad  = ifa.led_deny;
                    alk = ifa.locked;
                    at  = int'(ifa.tries_left);
                    ald = {2'b00, ifa.ld_out};
                end else begin
                    ag  = ifb.led_grant;
                    ad  = ifb.led_deny;
                    alk = ifb.locked;
                    at  = int'(ifb.tries_left);
                    ald = ifb.ld_out;
                end
                vectors++;
                if (ag !== e.g || ad !== e.d || alk !== e.lk || at != e.t || ald !== e.ld) begin
                    miscompares++;
                    $display("FAIL %s: got grant=%b deny=%b locked=%b tries=%0d ld=%b, want grant=%b deny=%b locked=%b tries=%0d ld=%b",
                             e.nm, ag, ad, alk, at, ald, e.g, e.d, e.lk, e.t, e.ld);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin : stimulus
        Rst       = 1'b1;
        ifa.psh   = 1'b0;
        ifa.swtch = 1'b0;
        ifa.lock  = 1'b0;
        ifa.ldIn  = '0;
        ifb.psh   = 1'b0;
        ifb.swtch = 1'b0;
        ifb.lock  = 1'b0;
        ifb.ldIn  = '0;
        #2;
        exp_out(0, 0, 0, 0, 3, 4'b0000, "reset_held");
        -> chk_ev;
        @(negedge Clk);
        Rst = 1'b0;
        cyc(0, 0, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "reset_idle");

        // Correct code, then load pass-through and relock.
        code(6'b001101, 4);
        exp_out(0, 1, 0, 0, 3, 4'b0000, "s1_grant");
        cyc(0, 0, 0, 4'b0001);
        exp_out(0, 1, 0, 0, 3, 4'b0001, "s1_ld01");
        cyc(0, 0, 0, 4'b0011);
        exp_out(0, 1, 0, 0, 3, 4'b0011, "s1_ld11");
        cyc(0, 0, 1, 4'b0011);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s5_relock");

        // Wrong code with loads requested, then correct code.
        cyc(1, 1, 0, 4'b0000);
        cyc(1, 0, 0, 4'b0000);
        cyc(1, 1, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s2_partial");
        cyc(1, 0, 0, 4'b0011);
        exp_out(0, 0, 1, 0, 2, 4'b0000, "s2_deny");
        cyc(0, 0, 0, 4'b0011);
        exp_out(0, 0, 0, 0, 2, 4'b0000, "s2_deny_1cyc");
        code(6'b001101, 4);
        exp_out(0, 1, 0, 0, 3, 4'b0000, "s2_grant");
        cyc(0, 0, 1, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s2_relock");

        // Three back-to-back wrong codes, psh kept high through DENY.
        code(6'b000000, 4);
        exp_out(0, 0, 1, 0, 2, 4'b0000, "s3_deny1");
        cyc(1, 1, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 2, 4'b0000, "s3_drop1");
        code(6'b000000, 4);
        exp_out(0, 0, 1, 0, 1, 4'b0000, "s3_deny2");
        cyc(1, 1, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 1, 4'b0000, "s3_drop2");
        code(6'b000000, 4);
        exp_out(0, 0, 1, 0, 0, 4'b0000, "s3_deny3");
        for (int i = 0; i < 8; i++) begin
            cyc(1, i[0], (i == 3), 4'b0011);
            exp_out(0, 0, 0, 1, 0, 4'b0000, "s3_locked");
        end
        cyc(0, 0, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s3_unlocked");
        code(6'b001101, 4);
        exp_out(0, 1, 0, 0, 3, 4'b0000, "s3_grant");
        cyc(0, 0, 1, 4'b0000);

        // psh gap inside an entry.
        cyc(1, 1, 0, 4'b0000);
        cyc(1, 1, 0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, i[0], 0, 4'b0000);
            exp_out(0, 0, 0, 0, 3, 4'b0000, "s4_gap");
        end
        cyc(1, 0, 0, 4'b0000);
        cyc(1, 1, 0, 4'b0000);
        exp_out(0, 1, 0, 0, 3, 4'b0000, "s4_gap_grant");
        cyc(0, 0, 1, 4'b0000);

        // lock aborts a partial entry and beats psh in the same cycle.
        cyc(1, 1, 0, 4'b0000);
        cyc(1, 1, 0, 4'b0000);
        cyc(1, 0, 1, 4'b0000);
        cyc(1, 0, 0, 4'b0000);
        cyc(1, 1, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s4_abort_nodecision");
        cyc(0, 0, 1, 4'b0000);
        code(6'b001101, 4);
        exp_out(0, 1, 0, 0, 3, 4'b0000, "s4_abort_grant");
        cyc(0, 0, 1, 4'b0000);

        // Asynchronous reset in the middle of a lockout.
        for (int k = 0; k < 3; k++) begin
            code(6'b000000, 4);
            cyc(0, 0, 0, 4'b0000);
        end
        exp_out(0, 0, 0, 1, 0, 4'b0000, "s5_lock_entered");
        cyc(0, 0, 0, 4'b0000);
        exp_out(0, 0, 0, 1, 0, 4'b0000, "s5_lock_mid");
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s5_async_rst");
        -> chk_ev;
        @(negedge Clk);
        Rst = 1'b0;
        cyc(0, 0, 0, 4'b0000);
        exp_out(0, 0, 0, 0, 3, 4'b0000, "s5_post_rst");

        // Generalised instance.
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        cyc(0, 0, 0, 4'b0000);
        exp_out(1, 0, 0, 0, 1, 4'b0000, "s6_reset");
        code(6'b101100, 6);
        exp_out(1, 1, 0, 0, 1, 4'b0000, "s6_grant");
        cyc(0, 0, 0, 4'b1010);
        exp_out(1, 1, 0, 0, 1, 4'b1010, "s6_ld1010");
        cyc(0, 0, 0, 4'b1111);
        exp_out(1, 1, 0, 0, 1, 4'b1111, "s6_ld1111");
        cyc(0, 0, 1, 4'b1111);
        exp_out(1, 0, 0, 0, 1, 4'b0000, "s6_relock");
        code(6'b000000, 6);
        exp_out(1, 0, 1, 0, 0, 4'b0000, "s6_deny");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 4'b1111);
            exp_out(1, 0, 0, 1, 0, 4'b0000, "s6_locked");
        end
        cyc(0, 0, 0, 4'b0000);
        exp_out(1, 0, 0, 0, 1, 4'b0000, "s6_unlocked");
        code(6'b101100, 6);
        exp_out(1, 1, 0, 0, 1, 4'b0000, "s6_regrant");

        @(posedge Clk);
        #2;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
